inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
//   Parametrised instruction queue between IF and ID. Pairs each accepted fetch PC with the
//   synchronous inst SRAM data returned one cycle later. Holds up to DEPTH {pc,inst} entries
//   so ID stalls never lose a returned instruction. Flush on branch redirect squashes queued
//   and in-flight fetches. Optional bypass gives a 1-cycle fetch-to-ID path when empty.
// PARAMETERS
//   DEPTH   4   queue entries; power of two, >= 2
//   PC_W    32  PC width
//   INST_W  32  instruction width
//   BYPASS  1   1: SRAM data falls through to out_* when queue empty; 0: always via queue
// PORTS
//   clk              in   1                   clock
//   rst              in   1                   reset
//   flush            in   1                   branch redirect; squash older fetches
//   req_valid        in   1                   IF issues fetch (inst SRAM ce) this cycle
//   req_pc           in   PC_W                PC of issued fetch
//   req_ready        out  1                   queue can accept a fetch this cycle
//   inst_sram_rdata  in   INST_W              SRAM data, valid cycle after accepted req
//   out_valid        out  1                   entry presented to ID
//   out_pc           out  PC_W                PC of presented entry
//   out_inst         out  INST_W              instruction of presented entry
//   out_ready        in   1                   ID consumes entry (ID not stalled)
//   count            out  $clog2(DEPTH+1)     stored entries (excludes in-flight)
// BEHAVIOUR
//   - Reset: rst synchronous, active-high; clock clk. Queue empty, rd/wr ptr = 0, count = 0,
//     inflight = 0, out_valid = 0, out_pc = 0, out_inst = 0, req_ready = 1.
//   - Accept: req_valid & req_ready at cycle t -> inflight=1, inflight_pc=req_pc at edge t.
//   - Response: cycle t+1 with inflight=1 -> entry {inflight_pc, inst_sram_rdata}; written at
//     wr_ptr at edge t+1 unless consumed via bypass. inflight clears unless a new req accepted.
//   - req_ready = (count + inflight) < DEPTH; no pop credit. Overflow is impossible by design.
//   - Output: queue non-empty -> out_* = entry at rd_ptr. Queue empty & BYPASS & inflight ->
//     out_valid=1, out_pc=inflight_pc, out_inst=inst_sram_rdata. Otherwise out_valid=0.
//   - out_pc/out_inst are 0 whenever out_valid=0 (ID decodes a bubble).
//   - Pop: out_valid & out_ready pops head (rd_ptr++), or drops bypass entry without write.
//   - Push+pop same cycle: count unchanged, both pointers advance.
//   - Pointers wrap modulo DEPTH; count saturates by construction at DEPTH.
//   - Latency: BYPASS=1 req->out_valid 1 cycle; BYPASS=0 2 cycles.
//   - out_* stable while out_valid & ~out_ready (no change until pop or flush).
//   - Flush at cycle t: queue cleared at edge t (count=0, ptrs=0); response due at t (from
//     req accepted at t-1) discarded; out_valid=0 in cycle t; pops ignored.
//     A req accepted in cycle t (redirect target) is kept; its response enqueues at t+1.
//   - req_ready during flush evaluated as if queue and inflight already empty (=1).
//   - rst overrides flush and all other inputs; reset mid-stream drops all entries.
// TESTING
//   - Stream: BYPASS=1, req pc 0x0,0x4,0x8 cycles 1-3, out_ready=1 -> out_pc 0x0,0x4,0x8 in
//     cycles 2-4, count stays 0.
//   - Stall fill: out_ready=0, reqs 0x100.. every cycle -> count reaches 4, req_ready=0 once
//     count+inflight=4; out_pc held 0x100; release out_ready -> 0x100..0x10C in order, no loss.
//   - Wrap: DEPTH=4, 10 pushes with alternating stall -> pointers wrap, order 0x0..0x24 intact.
//   - Flush: queue holds 0x200,0x204, inflight 0x208, flush + req 0x400 same cycle -> 0x208
//     never appears, next out_pc = 0x400, count=0 after flush edge.
//   - BYPASS=0: single req 0x40 at cycle 1 -> out_valid first at cycle 3, out_inst = SRAM data.
//   - Reset mid-operation: count=3, assert rst -> next cycle out_valid=0, count=0, req_ready=1.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Instruction queue between IF and ID. Every accepted fetch PC is held as
//   "in flight" for one cycle. In the next cycle the synchronous inst SRAM
//   returns the data, and the pair {pc, inst} is stored in a DEPTH-entry
//   circular buffer. When BYPASS is set and the buffer is empty, the response
//   is handed straight to ID in the cycle it returns. A flush (branch redirect)
//   empties the buffer and discards the response due that cycle. A fetch
//   accepted in the flush cycle itself is kept.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             branch redirect, squashes queued and in-flight fetches
//   req_valid/req_pc  fetch issued by IF this cycle
//   req_ready         a fetch can be accepted this cycle
//   inst_sram_rdata   SRAM data for the fetch accepted in the previous cycle
//   out_valid/out_pc/out_inst  entry presented to ID (pc/inst are 0 when not valid)
//   out_ready         ID consumes the presented entry
//   count             number of stored entries (in-flight fetch not included)
module inst_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       req_valid,
  input  logic [PC_W-1:0]            req_pc,
  output logic                       req_ready,
  input  logic [INST_W-1:0]          inst_sram_rdata,
  output logic                       out_valid,
  output logic [PC_W-1:0]            out_pc,
  output logic [INST_W-1:0]          out_inst,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PC_W-1:0]   pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [PC_W-1:0]   inflight_pc_q, inflight_pc_d;

  logic              empty_s;
  logic              bypass_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic [CNT_W:0]    occupancy_s;

  assign empty_s     = (count_q == {CNT_W{1'b0}});
  // The SRAM response may only fall through when nothing older is queued.
  assign bypass_s    = (BYPASS != 0) && empty_s && inflight_q && !flush;
  assign occupancy_s = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign accept_s    = req_valid && req_ready;
  // Pops are gated by the valid signal, which is already forced low during flush.
  assign pop_s       = out_valid && out_ready && !empty_s;
  // A response is stored unless flush squashes it or ID takes it through the bypass.
  assign push_s      = inflight_q && !flush && !(bypass_s && out_ready);
  assign count       = count_q;

  // Fetch acceptance: no pop credit; during flush the queue counts as already empty.
  always_comb begin
    req_ready = 1'b1;
    if (flush) begin
      req_ready = 1'b1;
    end else begin
      req_ready = (occupancy_s < (CNT_W+1)'(DEPTH));
    end
  end

  // Output selection: queue head, bypassed SRAM response, or a zeroed bubble.
  always_comb begin
    out_valid = 1'b0;
    out_pc    = {PC_W{1'b0}};
    out_inst  = {INST_W{1'b0}};
    if (flush) begin
      out_valid = 1'b0;
    end else if (!empty_s) begin
      out_valid = 1'b1;
      out_pc    = pc_mem_q[rd_ptr_q];
      out_inst  = inst_mem_q[rd_ptr_q];
    end else if (bypass_s) begin
      out_valid = 1'b1;
      out_pc    = inflight_pc_q;
      out_inst  = inst_sram_rdata;
    end else begin
      out_valid = 1'b0;
    end
  end

  // Next-state computation for pointers, occupancy and the in-flight fetch.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    inflight_d    = accept_s;
    inflight_pc_d = inflight_pc_q;
    if (accept_s) begin
      inflight_pc_d = req_pc;
    end else begin
      inflight_pc_d = inflight_pc_q;
    end
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      count_q       <= {CNT_W{1'b0}};
      inflight_q    <= 1'b0;
      inflight_pc_q <= {PC_W{1'b0}};
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // Entry storage. Contents are only read while count is non-zero, so they need no reset.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
      inst_mem_q[wr_ptr_q] <= inst_sram_rdata;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

  localparam logic [31:0] K = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, out_ready;
  logic [31:0] req_pc;
  logic [31:0] rdata = 32'h0;

  logic        rr1, ov1, rr0, ov0;
  logic [31:0] opc1, oinst1, opc0, oinst0;
  logic [2:0]  cnt1, cnt0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // SRAM model: data is a fixed function of the PC presented in the previous cycle.
  always @(posedge clk) rdata <= req_pc ^ K;

  inst_fetch_queue #(.DEPTH(4), .PC_W(32), .INST_W(32), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_pc(req_pc),
    .req_ready(rr1), .inst_sram_rdata(rdata), .out_valid(ov1), .out_pc(opc1),
    .out_inst(oinst1), .out_ready(out_ready), .count(cnt1));

  inst_fetch_queue #(.DEPTH(4), .PC_W(32), .INST_W(32), .BYPASS(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_pc(req_pc),
    .req_ready(rr0), .inst_sram_rdata(rdata), .out_valid(ov0), .out_pc(opc0),
    .out_inst(oinst0), .out_ready(out_ready), .count(cnt0));

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic        rv;
    logic [31:0] pc;
    logic        ordy;
    logic        eov;
    logic [31:0] epc;
    logic [2:0]  ecnt;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic rv, input logic [31:0] pc,
                     input logic ordy, input logic eov, input logic [31:0] epc,
                     input logic [2:0] ecnt, input logic err);
    vec_t v;
    v.rst = r; v.flush = f; v.rv = rv; v.pc = pc; v.ordy = ordy;
    v.eov = eov; v.epc = epc; v.ecnt = ecnt; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic f, input logic rv, input logic [31:0] pc,
                       input logic ordy);
    @(negedge clk);
    rst = r; flush = f; req_valid = rv; req_pc = pc; out_ready = ordy;
    #1;
  endtask

  initial begin
    int idx1, idx0, nsent;
    logic [31:0] e_inst;

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_pc = 32'h0; out_ready = 1'b0;

    //   rst   flush rv    pc          ordy  eov   epc         cnt   rr
    // reset state
    add(1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 3'd0, 1'b1);
    // stream with bypass
    add(1'b0, 1'b0, 1'b1, 32'h000, 1'b1, 1'b0, 32'h000, 3'd0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h004, 1'b1, 1'b1, 32'h000, 3'd0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h008, 1'b1, 1'b1, 32'h004, 3'd0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 32'h008, 3'd0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 32'h000, 3'd0, 1'b1);
    // stall fill to DEPTH, then drain
    add(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h000, 3'd0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h104, 1'b0, 1'b1, 32'h100, 3'd0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h108, 1'b0, 1'b1, 32'h100, 3'd1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h10C, 1'b0, 1'b1, 32'h100, 3'd2, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h110, 1'b0, 1'b1, 32'h100, 3'd3, 1'b0);
    add(1'b0, 1'b0, 1'b1, 32'h110, 1'b0, 1'b1, 32'h100, 3'd4, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 32'h100, 3'd4, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 32'h104, 3'd3, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 32'h108, 3'd2, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 32'h10C, 3'd1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 32'h000, 3'd0, 1'b1);
    // flush with redirect request in the same cycle
    add(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h000, 3'd0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h204, 1'b0, 1'b1, 32'h200, 3'd0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h208, 1'b0, 1'b1, 32'h200, 3'd1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 32'h400, 1'b1, 1'b0, 32'h000, 3'd2, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 32'h400, 3'd0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 32'h000, 3'd0, 1'b1);
    // reset with three stored entries
    add(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h000, 3'd0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h304, 1'b0, 1'b1, 32'h300, 3'd0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h308, 1'b0, 1'b1, 32'h300, 3'd1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b1, 32'h300, 3'd2, 1'b1);
    add(1'b1, 1'b0, 1'b0, 32'h000, 1'b0, 1'b1, 32'h300, 3'd3, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 3'd0, 1'b1);
    // push and pop in the same cycle keep count constant
    add(1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 32'h000, 3'd0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h504, 1'b0, 1'b1, 32'h500, 3'd0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'h508, 1'b1, 1'b1, 32'h500, 3'd1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 32'h504, 3'd1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 32'h508, 3'd1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 32'h000, 3'd0, 1'b1);

    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].rv, vecs[i].pc, vecs[i].ordy);
      e_inst = vecs[i].eov ? (vecs[i].epc ^ K) : 32'h0;
      chk($sformatf("v%0d out_valid", i), {31'h0, ov1}, {31'h0, vecs[i].eov});
      chk($sformatf("v%0d out_pc", i), opc1, vecs[i].epc);
      chk($sformatf("v%0d out_inst", i), oinst1, e_inst);
      chk($sformatf("v%0d count", i), {29'h0, cnt1}, {29'h0, vecs[i].ecnt});
      chk($sformatf("v%0d req_ready", i), {31'h0, rr1}, {31'h0, vecs[i].err});
    end

    // BYPASS=0: single fetch appears two cycles later, via the queue
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b1);
    chk("nobyp c1 out_valid", {31'h0, ov0}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("nobyp c2 out_valid", {31'h0, ov0}, 32'h0);
    chk("nobyp c2 out_pc", opc0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("nobyp c3 out_valid", {31'h0, ov0}, 32'h1);
    chk("nobyp c3 out_pc", opc0, 32'h40);
    chk("nobyp c3 out_inst", oinst0, 32'h40 ^ K);
    chk("nobyp c3 count", {29'h0, cnt0}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("nobyp c4 out_valid", {31'h0, ov0}, 32'h0);

    // Wrap: ten fetches with alternating stall, order checked on both variants
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    idx1 = 0; idx0 = 0; nsent = 0;
    for (int c = 0; c < 80 && !(idx1 == 10 && idx0 == 10); c++) begin
      @(negedge clk);
      rst = 1'b0; flush = 1'b0; out_ready = c[0];
      if (nsent < 10 && rr1 && rr0) begin
        req_valid = 1'b1; req_pc = 32'(nsent * 4); nsent++;
      end else begin
        req_valid = 1'b0; req_pc = 32'h0;
      end
      #1;
      if (ov1 && out_ready) begin
        chk($sformatf("wrap byp pc%0d", idx1), opc1, 32'(idx1 * 4));
        chk($sformatf("wrap byp inst%0d", idx1), oinst1, 32'(idx1 * 4) ^ K);
        idx1++;
      end
      if (ov0 && out_ready) begin
        chk($sformatf("wrap nobyp pc%0d", idx0), opc0, 32'(idx0 * 4));
        chk($sformatf("wrap nobyp inst%0d", idx0), oinst0, 32'(idx0 * 4) ^ K);
        idx0++;
      end
    end
    chk("wrap byp received", 32'(idx1), 32'd10);
    chk("wrap nobyp received", 32'(idx0), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
